corefifo_gray_conv_pipe: RTL and testbench

- Parametrised, pipelined Gray/binary code converter for CoreFIFO pointer paths, with a valid/ready handshake.
- Successor to the combinational Gray-to-binary converter. Adds a selectable conversion direction, a configurable pipeline depth that splits the MSB-first XOR chain, and backpressure.
- Also checks that successive Gray inputs differ by at most one bit, which catches corrupted synchronised FIFO pointers.
- Sits between the pointer synchroniser and the full/empty comparators.

---
 rtl/corefifo_gray_conv_pipe.sv | 114 +++++++++++
 tb/tb_corefifo_gray_conv_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/corefifo_gray_conv_pipe.sv
// Pipelined Gray<->binary converter for CoreFIFO pointer paths, with a
// valid/ready handshake and a Gray single-bit-step checker on the input.
module corefifo_gray_conv_pipe #(
    parameter int ADDRWIDTH = 3,
    parameter int STAGES    = 2,
    parameter int MODE      = 0,
    parameter int ERRCNT_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDRWIDTH:0]  code_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ADDRWIDTH:0]  code_out,
    output logic                err_flag,
    output logic [ERRCNT_W-1:0] err_cnt,
    input  logic                err_clr
);
    localparam int W = ADDRWIDTH + 1;
    localparam int C = (W + STAGES - 1) / STAGES;

    logic                      adv;
    logic                      acc_in;
    logic                      step_err;
    logic [STAGES:1]           vld_pipe;
    logic [STAGES:1][W-1:0]    dat_pipe;
    logic [STAGES:1][W-1:0]    stg_in;
    logic [STAGES:1][W-1:0]    stg_nxt;
    logic [W-1:0]              prev_code;
    logic                      prev_valid;

    // Whole pipe advances together; bubbles travel with the data.
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign acc_in    = in_valid & adv;
    assign out_valid = vld_pipe[STAGES];
    assign code_out  = dat_pipe[STAGES];

    always_comb begin
        stg_in    = '0;
        stg_in[1] = code_in;
        for (int s = 2; s <= STAGES; s++)
            stg_in[s] = dat_pipe[s-1];
    end

    // Stage s resolves its chunk of binary bits MSB-first; bits above the
    // chunk are already binary, bits below are still Gray.
    always_comb begin : p_conv
        logic [W-1:0] x;
        int hi, lo;
        stg_nxt = '0;
        x  = '0;
        hi = 0;
        lo = 0;
        for (int s = 1; s <= STAGES; s++) begin
            x  = stg_in[s];
            hi = ADDRWIDTH - (s - 1) * C;
            lo = ADDRWIDTH - s * C + 1;
            if (MODE == 0) begin
                for (int i = W - 2; i >= 0; i--)
                    if (i >= lo && i <= hi)
                        x[i] = x[i+1] ^ x[i];
            end else if (s == 1) begin
                x = x ^ (x >> 1);
            end
            stg_nxt[s] = x;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else if (adv) begin
            vld_pipe[1] <= in_valid;
            dat_pipe[1] <= stg_nxt[1];
            for (int s = 2; s <= STAGES; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                dat_pipe[s] <= stg_nxt[s];
            end
        end
    end

    // A synchronised Gray pointer may repeat or move one bit, never more.
    assign step_err = (MODE == 0) && acc_in && prev_valid &&
                      ($countones(code_in ^ prev_code) > 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_code  <= '0;
            prev_valid <= 1'b0;
        end else if (acc_in) begin
            prev_code  <= code_in;
            prev_valid <= 1'b1;
        end
    end

    // Clear takes effect before a same-cycle error is counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_flag <= 1'b0;
            err_cnt  <= '0;
        end else if (err_clr) begin
            err_flag <= step_err;
            err_cnt  <= ERRCNT_W'(step_err);
        end else if (step_err) begin
            err_flag <= 1'b1;
            if (err_cnt != '1)
                err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end
endmodule

// File: tb/tb_corefifo_gray_conv_pipe.sv
// Scoreboard bench: dut0 is Gray->binary over 2 stages with a 2-bit error
// counter, dut1 is binary->Gray over 4 stages.
module tb_corefifo_gray_conv_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]      v, ordy, clr;
    logic [1:0][3:0] ci;
    wire  [1:0]      ir, ov, ef;
    wire  [1:0][3:0] co;
    wire  [1:0]      ec0;
    wire  [7:0]      ec1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] code;
        int         acc;
        bit         lat;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    corefifo_gray_conv_pipe #(.ADDRWIDTH(3), .STAGES(2), .MODE(0), .ERRCNT_W(2)) dut0 (
        .clk(clk), .reset(reset), .in_valid(v[0]), .in_ready(ir[0]), .code_in(ci[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .code_out(co[0]),
        .err_flag(ef[0]), .err_cnt(ec0), .err_clr(clr[0]));

    corefifo_gray_conv_pipe #(.ADDRWIDTH(3), .STAGES(4), .MODE(1), .ERRCNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .in_valid(v[1]), .in_ready(ir[1]), .code_in(ci[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .code_out(co[1]),
        .err_flag(ef[1]), .err_cnt(ec1), .err_clr(clr[1]));

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_out(input int k, input logic [3:0] got);
        exp_t e;
        int   lat;
        lat = (k == 0) ? 1 : 3;
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL out%0d_unexpected: got %b, expected no output", k, got);
            return;
        end
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        check($sformatf("out%0d_code", k), int'(got), int'(e.code));
        if (e.lat) check($sformatf("out%0d_latency", k), cyc, e.acc + lat);
    endtask

    always @(negedge clk) begin
        if (ov[0] && ordy[0]) chk_out(0, co[0]);
        if (ov[1] && ordy[1]) chk_out(1, co[1]);
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int k, input logic [3:0] c, input logic [3:0] e, input bit lat);
        exp_t x;
        int   n;
        n     = 0;
        v[k]  = 1'b1;
        ci[k] = c;
        do begin
            @(negedge clk);
            n++;
        end while (!ir[k] && n < 20);
        if (!ir[k]) begin
            n_vec++;
            n_err++;
            $display("FAIL send%0d_timeout: in_ready stayed 0, expected 1", k);
            v[k] = 1'b0;
            return;
        end
        x.code = e;
        x.acc  = cyc + 1;
        x.lat  = lat;
        if (k == 0) q0.push_back(x);
        else        q1.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        v = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        v     = '0;
        ordy  = 2'b11;
        clr   = '0;
        ci    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid0", ov[0], 0);
        check("rst_code_out0", co[0], 0);
        check("rst_err_flag0", ef[0], 0);
        check("rst_err_cnt0", ec0, 0);
        check("rst_in_ready0", ir[0], 1);
        check("rst_out_valid1", ov[1], 0);
        check("rst_err_cnt1", ec1, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full Gray sweep including the legal wrap back to zero
        for (int i = 0; i < 16; i++) send(0, gtab[i], 4'(i), 1'b1);
        send(0, 4'b0000, 4'b0000, 1'b1);
        idle(4);
        check("sweep_err_flag", ef[0], 0);
        check("sweep_err_cnt", ec0, 0);

        // Illegal steps, counter saturation at 3
        send(0, 4'b0000, 4'b0000, 1'b1);
        send(0, 4'b0011, 4'b0010, 1'b1);
        check("err1_flag", ef[0], 1);
        check("err1_cnt", ec0, 1);
        send(0, 4'b0110, 4'b0100, 1'b1);
        check("err2_cnt", ec0, 2);
        send(0, 4'b1001, 4'b1110, 1'b1);
        send(0, 4'b0110, 4'b0100, 1'b1);
        send(0, 4'b1001, 4'b1110, 1'b1);
        check("sat_cnt", ec0, 3);
        check("sat_flag", ef[0], 1);
        clr[0] = 1'b1;
        send(0, 4'b0110, 4'b0100, 1'b1);
        clr[0] = 1'b0;
        v      = '0;
        check("clr_err_flag", ef[0], 1);
        check("clr_err_cnt", ec0, 1);
        clr[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        check("clr_only_flag", ef[0], 0);
        check("clr_only_cnt", ec0, 0);
        idle(4);

        // Backpressure: stall with a full pipe, then release
        ordy[0] = 1'b0;
        fork
            begin
                send(0, 4'b0111, 4'b0101, 1'b0);
                send(0, 4'b0101, 4'b0110, 1'b0);
                send(0, 4'b0100, 4'b0111, 1'b0);
                send(0, 4'b1100, 4'b1000, 1'b0);
                send(0, 4'b1101, 4'b1001, 1'b0);
                v[0] = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                check("stall_in_ready", ir[0], 0);
                check("stall_out_valid", ov[0], 1);
                check("stall_code", co[0], 4'b0101);
                repeat (2) @(negedge clk);
                check("stall_code_held", co[0], 4'b0101);
                check("stall_in_ready_held", ir[0], 0);
                @(posedge clk);
                #1;
                ordy[0] = 1'b1;
            end
        join
        idle(4);
        check("bp_err_flag", ef[0], 0);

        // Binary->Gray over 4 stages; large jumps are not errors here
        send(1, 4'b1011, 4'b1110, 1'b1);
        send(1, 4'b0000, 4'b0000, 1'b1);
        send(1, 4'b1111, 4'b1000, 1'b1);
        send(1, 4'b0101, 4'b0111, 1'b1);
        idle(6);
        check("m1_err_flag", ef[1], 0);
        check("m1_err_cnt", ec1, 0);

        // Reset with codes in flight
        send(0, 4'b0001, 4'b0001, 1'b1);
        send(0, 4'b0011, 4'b0010, 1'b1);
        v     = '0;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", ov[0], 0);
        check("midrst_code_out", co[0], 0);
        check("midrst_err_flag", ef[0], 0);
        q0.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(0, 4'b0000, 4'b0000, 1'b1);
        check("post_rst_first_flag", ef[0], 0);
        send(0, 4'b1111, 4'b1010, 1'b1);
        v = '0;
        check("post_rst_d4_flag", ef[0], 1);
        check("post_rst_d4_cnt", ec0, 1);
        idle(4);

        // First code after reset is only captured, never compared
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(0, 4'b0110, 4'b0100, 1'b1);
        v = '0;
        check("first_code_flag", ef[0], 0);
        check("first_code_cnt", ec0, 0);
        idle(6);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
